// File: rtl/debug_seq_ctrl.sv
// debug_seq_ctrl: multi-channel debug load/store sequencer on REG_BUS.
// Define DEBUG_SEQ_WDOG_EN to add the DONE-state watchdog at word 124.
module debug_seq_ctrl #(
   parameter int NUM_CH      = 4,
   parameter int NUM_SCRATCH = 16,
   parameter int CNT_W       = 8,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [7:0]            reglk_ctrl_i,
   input  logic [ADDR_WIDTH-1:0] reg_addr_i,
   input  logic                  reg_write_i,
   input  logic [DATA_WIDTH-1:0] reg_wdata_i,
   input  logic [3:0]            reg_wstrb_i,
   input  logic                  reg_valid_i,
   output logic [DATA_WIDTH-1:0] reg_rdata_o,
   output logic                  reg_ready_o,
   output logic                  reg_error_o,
   output logic [NUM_CH-1:0]     busy_o,
   output logic                  done_irq_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_LOAD  = 3'd2,
      S_STORE = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   localparam logic [7:0] A_CMD   = 8'd0;
   localparam logic [7:0] A_STAT  = 8'd1;
   localparam logic [7:0] A_LC    = 8'd2;
   localparam logic [7:0] A_DONE  = 8'd3;
   localparam logic [7:0] A_SNAP  = 8'd4;
   localparam logic [7:0] A_SNAPE = 8'd11;
   localparam logic [7:0] A_SCR   = 8'd12;
   localparam logic [7:0] A_SCRE  = 8'(12 + NUM_SCRATCH);
`ifdef DEBUG_SEQ_WDOG_EN
   localparam logic [7:0] A_WDOG  = 8'd124;
`endif

   state_e            state_q [NUM_CH];
   state_e            state_d [NUM_CH];
   logic [CNT_W-1:0]  cnt_q   [NUM_CH];
   logic [CNT_W-1:0]  cnt_d   [NUM_CH];
   logic [7:0]        snap_q  [NUM_CH];
   logic [7:0]        snap_d  [NUM_CH];
   logic [NUM_CH-1:0] done_q, done_d;
   logic [CNT_W-1:0]  lc_q, lc_d;
   logic [31:0]       scr_q   [NUM_SCRATCH];
   logic [NUM_SCRATCH-1:0] scr_we;

`ifdef DEBUG_SEQ_WDOG_EN
   logic [15:0]       wdog_q, wdog_d;
   logic [15:0]       wcnt_q  [NUM_CH];
   logic [15:0]       wcnt_d  [NUM_CH];
   logic [NUM_CH-1:0] wflag_q, wflag_d;
   logic              wd_we;
`endif

   logic [7:0]        widx;
   logic              wr;
   logic [31:0]       wmask, wdata_m;
   logic [31:0]       rdata, status;
   logic              err, cmd_we, lc_we;
   logic [NUM_CH-1:0] start, abort, clr;
   logic              unused_addr;

   assign widx        = {1'b0, reg_addr_i[8:2]};
   assign unused_addr = ^{reg_addr_i[ADDR_WIDTH-1:9], reg_addr_i[1:0]};
   assign wr          = reg_valid_i & reg_write_i;
   assign wmask       = {{8{reg_wstrb_i[3]}}, {8{reg_wstrb_i[2]}},
                         {8{reg_wstrb_i[1]}}, {8{reg_wstrb_i[0]}}};
   assign wdata_m     = reg_wdata_i[31:0] & wmask;
   assign lc_d        = (lc_q & ~wmask[CNT_W-1:0]) | wdata_m[CNT_W-1:0];
`ifdef DEBUG_SEQ_WDOG_EN
   assign wdog_d      = (wdog_q & ~wmask[15:0]) | wdata_m[15:0];
`endif

   assign start = cmd_we ? wdata_m[NUM_CH-1:0]    : '0;
   assign abort = cmd_we ? wdata_m[8 +: NUM_CH]   : '0;
   assign clr   = cmd_we ? wdata_m[16 +: NUM_CH]  : '0;

   always_comb begin
      status = '0;
      for (int c = 0; c < NUM_CH; c++) begin
`ifdef DEBUG_SEQ_WDOG_EN
         status[4*c +: 4] = {wflag_q[c], state_q[c]};
`else
         status[4*c +: 4] = {1'b0, state_q[c]};
`endif
      end
   end

   always_comb begin
      rdata  = '0;
      err    = 1'b0;
      cmd_we = 1'b0;
      lc_we  = 1'b0;
      scr_we = '0;
`ifdef DEBUG_SEQ_WDOG_EN
      wd_we  = 1'b0;
`endif
      if (widx == A_CMD) begin
         err    = wr & reglk_ctrl_i[0];
         cmd_we = wr & ~reglk_ctrl_i[0];
      end else if (widx == A_STAT) begin
         rdata = status;
         err   = wr;
      end else if (widx == A_LC) begin
         rdata = 32'(lc_q);
         err   = wr & reglk_ctrl_i[0];
         lc_we = wr & ~reglk_ctrl_i[0];
      end else if (widx == A_DONE) begin
         rdata = 32'(done_q);
         err   = wr;
      end else if (widx >= A_SNAP && widx <= A_SNAPE) begin
         for (int c = 0; c < NUM_CH; c++)
            if (widx == 8'(4 + c)) rdata = {24'b0, snap_q[c]};
         err = wr;
      end
`ifdef DEBUG_SEQ_WDOG_EN
      else if (widx == A_WDOG) begin
         rdata = {16'b0, wdog_q};
         wd_we = wr;
      end
`endif
      else if (widx >= A_SCR && widx < A_SCRE) begin
         for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (widx == 8'(12 + i)) begin
               rdata     = scr_q[i];
               scr_we[i] = wr & ~reglk_ctrl_i[1];
            end
         end
         err = wr & reglk_ctrl_i[1];
      end else begin
         err = reg_valid_i;
      end
   end

   always_comb begin
      done_d = done_q;
`ifdef DEBUG_SEQ_WDOG_EN
      wflag_d = wflag_q;
`endif
      for (int c = 0; c < NUM_CH; c++) begin
         state_d[c] = state_q[c];
         cnt_d[c]   = cnt_q[c];
         snap_d[c]  = snap_q[c];
`ifdef DEBUG_SEQ_WDOG_EN
         wcnt_d[c]  = '0;
`endif
         if (clr[c]) done_d[c] = 1'b0;
         // abort outranks every other command and transition
         if (abort[c]) begin
            state_d[c] = S_IDLE;
         end else begin
            unique case (state_q[c])
               S_IDLE: if (start[c]) state_d[c] = S_START;
               S_START: begin
                  cnt_d[c]   = lc_q;
                  state_d[c] = S_LOAD;
               end
               S_LOAD: begin
                  if (cnt_q[c] == '0) state_d[c] = S_STORE;
                  else                cnt_d[c]   = cnt_q[c] - 1'b1;
               end
               S_STORE: begin
                  snap_d[c]  = reglk_ctrl_i;
                  done_d[c]  = 1'b1;
                  state_d[c] = S_DONE;
               end
               S_DONE: begin
                  if (start[c]) begin
                     state_d[c] = S_START;
                  end
`ifdef DEBUG_SEQ_WDOG_EN
                  else if (wdog_q != '0) begin
                     if (wcnt_q[c] >= wdog_q - 16'd1) begin
                        state_d[c] = S_IDLE;
                        wflag_d[c] = 1'b1;
                     end else begin
                        wcnt_d[c] = wcnt_q[c] + 16'd1;
                     end
                  end
`endif
               end
               default: state_d[c] = S_IDLE;
            endcase
         end
`ifdef DEBUG_SEQ_WDOG_EN
         if (state_d[c] == S_START) wflag_d[c] = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lc_q   <= '0;
         done_q <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c] <= S_IDLE;
            cnt_q[c]   <= '0;
            snap_q[c]  <= '0;
         end
         for (int i = 0; i < NUM_SCRATCH; i++) scr_q[i] <= '0;
`ifdef DEBUG_SEQ_WDOG_EN
         wdog_q  <= '0;
         wflag_q <= '0;
         for (int c = 0; c < NUM_CH; c++) wcnt_q[c] <= '0;
`endif
      end else begin
         if (lc_we) lc_q <= lc_d;
         done_q <= done_d;
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c] <= state_d[c];
            cnt_q[c]   <= cnt_d[c];
            snap_q[c]  <= snap_d[c];
         end
         for (int i = 0; i < NUM_SCRATCH; i++)
            if (scr_we[i]) scr_q[i] <= (scr_q[i] & ~wmask) | wdata_m;
`ifdef DEBUG_SEQ_WDOG_EN
         if (wd_we) wdog_q <= wdog_d;
         wflag_q <= wflag_d;
         for (int c = 0; c < NUM_CH; c++) wcnt_q[c] <= wcnt_d[c];
`endif
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_CH; c++)
         busy_o[c] = (state_q[c] != S_IDLE) && (state_q[c] != S_DONE);
   end

   assign reg_rdata_o = DATA_WIDTH'(rdata);
   assign reg_ready_o = reg_valid_i;
   assign reg_error_o = err;
   assign done_irq_o  = |done_q;

endmodule

// File: tb/tb_debug_seq_ctrl.sv
// Directed bench for debug_seq_ctrl: bus map, locks, channel sequencing.
// Watchdog vectors run when DEBUG_SEQ_WDOG_EN is defined.
module tb_debug_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  reglk = 8'h00;
   logic [31:0] addr = '0;
   logic        write = 1'b0;
   logic [31:0] wdata = '0;
   logic [3:0]  strb = 4'h0;
   logic        valid = 1'b0;
   logic [31:0] rdata;
   logic        ready, error, irq;
   logic [3:0]  busy;

   logic [31:0] d;
   logic        e;
   logic        rd_irq, rd_rdy;
   int          n_chk = 0;
   int          n_err = 0;

   logic [31:0] exp_seq [9] = '{1, 2, 2, 2, 2, 2, 2, 3, 4};

   always #5 clk = ~clk;

   debug_seq_ctrl dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .reglk_ctrl_i(reglk),
      .reg_addr_i  (addr),
      .reg_write_i (write),
      .reg_wdata_i (wdata),
      .reg_wstrb_i (strb),
      .reg_valid_i (valid),
      .reg_rdata_o (rdata),
      .reg_ready_o (ready),
      .reg_error_o (error),
      .busy_o      (busy),
      .done_irq_o  (irq)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] v,
                         input logic [3:0] s, output logic er);
      addr  = a;
      wdata = v;
      strb  = s;
      write = 1'b1;
      valid = 1'b1;
      #4;
      er = error;
      @(posedge clk);
      #1;
      valid = 1'b0;
      write = 1'b0;
   endtask

   task automatic bus_rd(input logic [31:0] a, output logic [31:0] v,
                         output logic er);
      addr  = a;
      write = 1'b0;
      valid = 1'b1;
      #4;
      v      = rdata;
      er     = error;
      rd_irq = irq;
      rd_rdy = ready;
      @(posedge clk);
      #1;
      valid = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_err", 32'(error), 32'h0);
      check("rst_rdy", 32'(ready), 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      bus_rd(32'h04, d, e);
      check("rst_status", d, 32'h0);
      check("rst_status_err", 32'(e), 32'h0);
      check("rd_ready", 32'(rd_rdy), 32'h1);
      bus_rd(32'h0C, d, e);
      check("rst_done", d, 32'h0);
      bus_rd(32'h30, d, e);
      check("rst_scr0", d, 32'h0);
      check("rst_scr0_err", 32'(e), 32'h0);

      // ch0 with LOADCYC=5, snapshot of 0xA5
      bus_wr(32'h08, 32'd5, 4'hF, e);
      check("lc_wr_err", 32'(e), 32'h0);
      bus_rd(32'h08, d, e);
      check("lc_rd", d, 32'd5);
      bus_wr(32'h00, 32'h1, 4'hF, e);
      check("cmd_start_err", 32'(e), 32'h0);
      reglk = 8'hA5;
      for (int i = 0; i < 9; i++) begin
         bus_rd(32'h04, d, e);
         check($sformatf("seq%0d_state", i), d, exp_seq[i]);
         check($sformatf("seq%0d_irq", i), 32'(rd_irq), 32'(i == 8));
      end
      bus_rd(32'h10, d, e);
      check("snap0", d, 32'hA5);
      bus_rd(32'h0C, d, e);
      check("done_after_seq", d, 32'h1);
      bus_wr(32'h10, 32'h0, 4'hF, e);
      check("snap_ro_err", 32'(e), 32'h1);
      reglk = 8'h00;

      // abort leaves done, clear drops it
      bus_wr(32'h00, 32'h100, 4'hF, e);
      bus_rd(32'h04, d, e);
      check("abort_idle", d, 32'h0);
      bus_rd(32'h0C, d, e);
      check("abort_keeps_done", d, 32'h1);
      bus_wr(32'h00, 32'h10000, 4'hF, e);
      bus_rd(32'h0C, d, e);
      check("clr_done", d, 32'h0);
      check("clr_irq", 32'(rd_irq), 32'h0);

      // lock bit 0 blocks CMD and LOADCYC
      reglk = 8'h01;
      bus_wr(32'h00, 32'h1, 4'hF, e);
      check("lk_cmd_err", 32'(e), 32'h1);
      bus_wr(32'h08, 32'd7, 4'hF, e);
      check("lk_lc_err", 32'(e), 32'h1);
      bus_rd(32'h04, d, e);
      check("lk_stays_idle", d, 32'h0);
      bus_rd(32'h08, d, e);
      check("lk_lc_kept", d, 32'd5);
      reglk = 8'h00;

      // scratch, lock bit 1, byte strobes, range edges
      bus_wr(32'h30, 32'h12345678, 4'hF, e);
      check("scr_wr_err", 32'(e), 32'h0);
      reglk = 8'h02;
      bus_wr(32'h30, 32'hDEADBEEF, 4'hF, e);
      check("scr_lk_err", 32'(e), 32'h1);
      reglk = 8'h00;
      bus_rd(32'h30, d, e);
      check("scr_lk_kept", d, 32'h12345678);
      bus_wr(32'h30, 32'hAABBCCDD, 4'b0010, e);
      bus_rd(32'h30, d, e);
      check("scr_strb", d, 32'h1234CC78);
      bus_wr(32'h6C, 32'hCAFEF00D, 4'hF, e);
      bus_rd(32'h6C, d, e);
      check("scr_last", d, 32'hCAFEF00D);
      bus_rd(32'h70, d, e);
      check("unmap_rd_err", 32'(e), 32'h1);
      check("unmap_rd_data", d, 32'h0);

      // ch1 abort in LOAD; abort beats start
      bus_wr(32'h00, 32'h2, 4'hF, e);
      bus_rd(32'h04, d, e);
      check("ch1_start", d, 32'h10);
      bus_rd(32'h04, d, e);
      check("ch1_load", d, 32'h20);
      bus_wr(32'h00, 32'h202, 4'hF, e);
      check("ch1_abort_err", 32'(e), 32'h0);
      bus_rd(32'h04, d, e);
      check("ch1_idle", d, 32'h0);
      bus_rd(32'h0C, d, e);
      check("ch1_done0", d, 32'h0);

      // ch0 and ch3 together with LOADCYC=0
      bus_wr(32'h08, 32'd0, 4'hF, e);
      bus_wr(32'h00, 32'h9, 4'hF, e);
      bus_rd(32'h04, d, e);
      check("dual_s1", d, 32'h1001);
      bus_rd(32'h04, d, e);
      check("dual_s2", d, 32'h2002);
      bus_rd(32'h04, d, e);
      check("dual_s3", d, 32'h3003);
      check("dual_irq_lo", 32'(rd_irq), 32'h0);
      bus_rd(32'h04, d, e);
      check("dual_s4", d, 32'h4004);
      check("dual_irq_hi", 32'(rd_irq), 32'h1);
      bus_rd(32'h0C, d, e);
      check("dual_done", d, 32'h9);
      bus_wr(32'h04, 32'hFFFF, 4'hF, e);
      check("stat_ro_err", 32'(e), 32'h1);
      bus_wr(32'h00, 32'h90000, 4'hF, e);
      bus_rd(32'h0C, d, e);
      check("dual_clr", d, 32'h0);
      check("dual_irq_drop", 32'(rd_irq), 32'h0);
      bus_rd(32'h04, d, e);
      check("dual_hold", d, 32'h4004);
      bus_wr(32'h00, 32'hFF00, 4'hF, e);
      bus_rd(32'h04, d, e);
      check("abort_all", d, 32'h0);

`ifdef DEBUG_SEQ_WDOG_EN
      bus_wr(32'h1F0, 32'd4, 4'hF, e);
      check("wdog_wr_err", 32'(e), 32'h0);
      bus_rd(32'h1F0, d, e);
      check("wdog_rd", d, 32'd4);
      bus_wr(32'h00, 32'h1, 4'hF, e);
      for (int i = 0; i < 8; i++) begin
         bus_rd(32'h04, d, e);
         check($sformatf("wdog%0d_state", i), d,
               (i < 3) ? 32'(i + 1) : ((i < 7) ? 32'h4 : 32'h8));
      end
      bus_wr(32'h00, 32'h1, 4'hF, e);
      bus_rd(32'h04, d, e);
      check("wdog_flag_clr", d, 32'h1);
`else
      bus_rd(32'h1F0, d, e);
      check("w124_rd_err", 32'(e), 32'h1);
      check("w124_rd_data", d, 32'h0);
      bus_wr(32'h1F0, 32'd4, 4'hF, e);
      check("w124_wr_err", 32'(e), 32'h1);
`endif

      // reset mid-sequence clears snapshot and done
      bus_wr(32'h08, 32'd3, 4'hF, e);
      bus_wr(32'h00, 32'h4, 4'hF, e);
      #3;
      rst_n = 1'b0;
      #2;
      check("rst_mid_busy", 32'(busy), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus_rd(32'h04, d, e);
      check("rst_mid_status", d, 32'h0);
      bus_rd(32'h10, d, e);
      check("rst_mid_snap", d, 32'h0);
      bus_rd(32'h08, d, e);
      check("rst_mid_lc", d, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
